// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the single ROB writeback port between NREQ result sources.
// Round-robin grant with a ROB-head override; winner is registered onto wb_* one cycle later.
module wb_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_error,
    input  logic [5*NREQ-1:0]    req_ecause,
    input  logic [7*NREQ-1:0]    req_robid,
    input  logic [32*NREQ-1:0]   req_result,
    input  logic [6:0]           rob_head_robid,
    input  logic                 rob_flush,
    output logic                 wb_valid,
    output logic                 wb_error,
    output logic [4:0]           wb_ecause,
    output logic [6:0]           wb_robid,
    output logic [31:0]          wb_result
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;

    logic [4:0]      ecause_arr [NREQ];
    logic [6:0]      robid_arr  [NREQ];
    logic [31:0]     result_arr [NREQ];

    logic [NREQ-1:0] head_hit;
    logic            head_any;
    logic [PW-1:0]   head_idx;
    logic            rr_any;
    logic [PW-1:0]   rr_idx;
    logic            grant_any;
    logic [PW-1:0]   grant_idx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            ecause_arr[i] = req_ecause[5*i +: 5];
            robid_arr[i]  = req_robid[7*i +: 7];
            result_arr[i] = req_result[32*i +: 32];
            head_hit[i]   = req_valid[i] && (robid_arr[i] == rob_head_robid);
        end
    end

    // Head override: the lowest-indexed requester holding the retiring instruction wins.
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        head_any = 1'b0;
        head_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (head_hit[i]) begin
                head_any = 1'b1;
                head_idx = PW'(i);
            end
        end
    end

    // Round-robin scan starting at ptr; descending offset so the nearest valid requester is kept.
    always_comb begin
        rr_any = 1'b0;
        rr_idx = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (req_valid[c]) begin
                rr_any = 1'b1;
                rr_idx = PW'(c);
            end
        end
    end

    always_comb begin
        grant_any = (head_any || rr_any) && !rob_flush && !rst;
        grant_idx = head_any ? head_idx : rr_idx;
        ptr_next  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Payload registers load only on a grant; a flush clears the strobe and the pointer, not the data.
    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous and active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            wb_valid  <= 1'b0;
            wb_error  <= 1'b0;
            wb_ecause <= '0;
            wb_robid  <= '0;
            wb_result <= '0;
        end else begin
            wb_valid <= grant_any;
            if (rob_flush) begin
                ptr <= '0;
            end else if (grant_any && !head_any) begin
                ptr <= ptr_next;
            end
            if (grant_any) begin
                wb_error  <= req_error[grant_idx];
                wb_ecause <= ecause_arr[grant_idx];
                wb_robid  <= robid_arr[grant_idx];
                wb_result <= result_arr[grant_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_ready) && ((req_ready & ~req_valid) == '0));
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus protocol-legal random traffic,
// all compared against a rule-level reference model of grant choice and the writeback registers.
module tb_wb_arbiter;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_error;
    logic [5*NREQ-1:0]    req_ecause;
    logic [7*NREQ-1:0]    req_robid;
    logic [32*NREQ-1:0]   req_result;
    logic [6:0]           rob_head_robid;
    logic                 rob_flush;
    logic                 wb_valid;
    logic                 wb_error;
    logic [4:0]           wb_ecause;
    logic [6:0]           wb_robid;
    logic [31:0]          wb_result;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    logic        m_error = 1'b0;
    logic [4:0]  m_ecause = '0;
    logic [6:0]  m_robid = '0;
    logic [31:0] m_result = '0;

    int              last_grant;
    logic [NREQ-1:0] obs_ready;
    logic            obs_wb_valid_pre;

    always #5 clk = ~clk;

    wb_arbiter #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_error      (req_error),
        .req_ecause     (req_ecause),
        .req_robid      (req_robid),
        .req_result     (req_result),
        .rob_head_robid (rob_head_robid),
        .rob_flush      (rob_flush),
        .wb_valid       (wb_valid),
        .wb_error       (wb_error),
        .wb_ecause      (wb_ecause),
        .wb_robid       (wb_robid),
        .wb_result      (wb_result)
    );

    task automatic set_req(input int i, input logic err, input logic [4:0] ec,
                           input logic [6:0] rid, input logic [31:0] res);
        req_valid[i]           = 1'b1;
        req_error[i]           = err;
        req_ecause[5*i +: 5]   = ec;
        req_robid[7*i +: 7]    = rid;
        req_result[32*i +: 32] = res;
    endtask

    // Winner by the arbitration rules: head holder first (lowest index), else first valid from ptr onward.
    function automatic void model_pick(output int g, output bit by_head);
        g = -1;
        by_head = 1'b0;
        if (rst || rob_flush) return;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_robid[7*i +: 7] == rob_head_robid) begin
                g = i;
                by_head = 1'b1;
                return;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) begin
                g = (m_ptr + k) % NREQ;
                return;
            end
        end
    endfunction

    // One clock cycle: inputs are already applied at the preceding negedge.
    task automatic step(input string tag);
        int              g;
        bit              hd;
        logic [NREQ-1:0] exp_ready;
        model_pick(g, hd);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        #1;
        obs_ready        = req_ready;
        obs_wb_valid_pre = wb_valid;
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL %s req_ready got=%b expected=%b", tag, req_ready, exp_ready);
        end
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_error = 1'b0;
            m_ecause = '0; m_robid = '0; m_result = '0;
        end else begin
            m_valid = (g >= 0);
            if (rob_flush) m_ptr = 0;
            if (g >= 0) begin
                m_error  = req_error[g];
                m_ecause = req_ecause[5*g +: 5];
                m_robid  = req_robid[7*g +: 7];
                m_result = req_result[32*g +: 32];
                if (!hd) m_ptr = (g + 1) % NREQ;
            end
        end
        last_grant = g;
        #1;
        checks++;
        if ({wb_valid, wb_error, wb_ecause, wb_robid, wb_result} !==
            {m_valid, m_error, m_ecause, m_robid, m_result}) begin
            errors++;
            $display("FAIL %s wb got=%b/%b/%h/%h/%h expected=%b/%b/%h/%h/%h", tag,
                     wb_valid, wb_error, wb_ecause, wb_robid, wb_result,
                     m_valid, m_error, m_ecause, m_robid, m_result);
        end
        @(negedge clk);
    endtask

    task automatic flush_idle();
        rob_flush = 1'b1;
        req_valid = '0;
        step("flush_idle");
        rob_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rob_flush = 1'b0;
        req_valid = '0; req_error = '0; req_ecause = '0; req_robid = '0; req_result = '0;
        rob_head_robid = 7'd0;
        step("reset0");
        step("reset1");
        rst = 1'b0;
        step("idle0");
        step("idle1");
        checks++;
        if ({wb_valid, wb_error, wb_ecause, wb_robid, wb_result} !== 46'b0) begin
            errors++;
            $display("FAIL reset_wb got=%b/%b/%h/%h/%h expected=all zero",
                     wb_valid, wb_error, wb_ecause, wb_robid, wb_result);
        end
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got=%b expected=0000", obs_ready);
        end
    endtask

    task automatic test_single();
        rob_head_robid = 7'd100;
        set_req(1, 1'b0, 5'd0, 7'd5, 32'hDEADBEEF);
        step("single");
        req_valid[1] = 1'b0;
        checks++;
        if (obs_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_ready got=%b expected=0010", obs_ready);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_robid !== 7'd5 || wb_result !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_wb got=%b/%h/%h expected=1/05/deadbeef", wb_valid, wb_robid, wb_result);
        end
        step("single_idle");
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop wb_valid got=%b expected=0", wb_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp;
        flush_idle();
        rob_head_robid = 7'd100;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'(i), 7'(10 + i), $urandom);
        for (int n = 0; n < 8; n++) begin
            step("rr");
            exp = 4'b0001 << (n % NREQ);
            checks++;
            if (obs_ready !== exp) begin
                errors++;
                $display("FAIL rr_order cycle %0d got=%b expected=%b", n, obs_ready, exp);
            end
            checks++;
            if (wb_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_wb_valid cycle %0d got=%b expected=1", n, wb_valid);
            end
            if (last_grant >= 0) set_req(last_grant, 1'b0, 5'(n), 7'(10 + last_grant), $urandom);
        end
        flush_idle();
    endtask

    task automatic test_head_override();
        flush_idle();
        set_req(0, 1'b0, 5'd0, 7'd9, 32'h0000_0009);
        set_req(2, 1'b0, 5'd0, 7'd3, 32'h0000_3333);
        rob_head_robid = 7'd3;
        step("head");
        req_valid[2] = 1'b0;
        checks++;
        if (obs_ready !== 4'b0100) begin
            errors++;
            $display("FAIL head_ready got=%b expected=0100", obs_ready);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_robid !== 7'd3 || wb_result !== 32'h0000_3333) begin
            errors++;
            $display("FAIL head_wb got=%b/%h/%h expected=1/03/00003333", wb_valid, wb_robid, wb_result);
        end
        step("head_rr");
        req_valid[0] = 1'b0;
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++;
            $display("FAIL head_then_rr got=%b expected=0001", obs_ready);
        end
        rob_head_robid = 7'd100;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 7'(20 + i), $urandom);
        step("head_ptr");
        checks++;
        if (obs_ready !== 4'b0010) begin
            errors++;
            $display("FAIL head_ptr_after got=%b expected=0010", obs_ready);
        end
        flush_idle();
    endtask

    task automatic test_flush();
        flush_idle();
        rob_head_robid = 7'd100;
        set_req(1, 1'b0, 5'd0, 7'd41, 32'h1111_0001);
        step("flush_pre");
        req_valid[1] = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 7'(40 + i), $urandom);
        rob_flush = 1'b1;
        step("flush");
        rob_flush = 1'b0;
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++;
            $display("FAIL flush_ready got=%b expected=0000", obs_ready);
        end
        checks++;
        if (obs_wb_valid_pre !== 1'b1) begin
            errors++;
            $display("FAIL flush_presented wb_valid got=%b expected=1", obs_wb_valid_pre);
        end
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill wb_valid got=%b expected=0", wb_valid);
        end
        req_valid = 4'b1000;
        step("flush_after");
        req_valid = '0;
        checks++;
        if (obs_ready !== 4'b1000) begin
            errors++;
            $display("FAIL flush_after_ready got=%b expected=1000", obs_ready);
        end
        set_req(1, 1'b0, 5'd0, 7'd45, 32'h1111_0002);
        step("flush_ptr_pre");
        req_valid = '0;
        flush_idle();
        set_req(1, 1'b0, 5'd0, 7'd46, 32'h1111_0003);
        set_req(2, 1'b0, 5'd0, 7'd47, 32'h1111_0004);
        step("flush_ptr");
        checks++;
        if (obs_ready !== 4'b0010) begin
            errors++;
            $display("FAIL flush_ptr_reset got=%b expected=0010", obs_ready);
        end
        flush_idle();
    endtask

    task automatic test_error_wrap();
        flush_idle();
        rob_head_robid = 7'd100;
        set_req(2, 1'b0, 5'd0, 7'd49, 32'h2222_0000);
        step("err_pre");
        req_valid = '0;
        set_req(0, 1'b0, 5'd0, 7'd50, 32'h5050_5050);
        set_req(3, 1'b1, 5'd4, 7'd51, 32'h5151_5151);
        step("err");
        req_valid[3] = 1'b0;
        checks++;
        if (obs_ready !== 4'b1000) begin
            errors++;
            $display("FAIL err_ready got=%b expected=1000", obs_ready);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_error !== 1'b1 || wb_ecause !== 5'd4 || wb_robid !== 7'd51) begin
            errors++;
            $display("FAIL err_wb got=%b/%b/%h/%h expected=1/1/04/33", wb_valid, wb_error, wb_ecause, wb_robid);
        end
        set_req(1, 1'b0, 5'd0, 7'd52, 32'h5252_5252);
        step("err_wrap");
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++;
            $display("FAIL err_wrap_ptr got=%b expected=0001", obs_ready);
        end
        flush_idle();
    endtask

    // Protocol-legal random traffic: payload held until a beat, drops only after a beat, flush or reset.
    task automatic test_random(input int n);
        int j;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, ($urandom_range(0, 3) == 0), 5'($urandom), 7'($urandom), $urandom);
            end
            rst       = ($urandom_range(0, 99) == 0);
            rob_flush = ($urandom_range(0, 15) == 0);
            j = $urandom_range(0, NREQ - 1);
            if ($urandom_range(0, 2) == 0 && req_valid[j])
                rob_head_robid = req_robid[7*j +: 7];
            else
                rob_head_robid = 7'($urandom);
            step("random");
            if (rst || rob_flush) begin
                for (int i = 0; i < NREQ; i++)
                    if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0;
            end else if (last_grant >= 0) begin
                req_valid[last_grant] = 1'b0;
            end
        end
        rst = 1'b0;
        flush_idle();
    endtask

    initial begin
        rst = 1'b1;
        rob_flush = 1'b0;
        req_valid = '0; req_error = '0; req_ecause = '0; req_robid = '0; req_result = '0;
        rob_head_robid = 7'd0;
        last_grant = -1;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_head_override();
        test_flush();
        test_error_wrap();
        test_random(600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Shares the single reorder-buffer writeback port between NREQ functional-unit result sources (ALU, branch, LSU, CSR/muldiv). Each cycle it grants at most one valid requester and registers the winner's result onto the wb_* bus one cycle later. Arbitration is round-robin, with a priority override for the requester holding the ROB-head instruction so that retirement is never blocked behind younger results. On a pipeline flush, all in-flight and pending results are discarded.

Parameters:
NREQ, 4, number of requesters (2..8); packed vector ports are indexed by requester i.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NREQ  requester i holds a result
req_ready  out  NREQ  requester i granted this cycle (one-hot or zero)
req_error  in  NREQ  exception flag per requester
req_ecause  in  5*NREQ  exception cause; slice [5i+4:5i]
req_robid  in  7*NREQ  ROB id; slice [7i+6:7i]
req_result  in  32*NREQ  result; slice [32i+31:32i]
rob_head_robid  in  7  ROB id currently being read for retirement
rob_flush  in  1  flush from the ROB; discards everything
wb_valid  out  1  registered writeback strobe to the ROB
wb_error  out  1  registered error flag
wb_ecause  out  5  registered cause
wb_robid  out  7  registered ROB id
wb_result  out  32  registered result

Behaviour:
- Reset: wb_valid=0; wb_error=0; wb_ecause=0; wb_robid=0; wb_result=0; RR pointer ptr=0. req_ready=0 while rst=1.
- Handshake: beat_i = req_valid[i] & req_ready[i]. req_ready is combinational from req_valid, rob_head_robid, and ptr.
  - A requester may drop req_valid only after its beat or on rob_flush.
  - Payload must be stable while req_valid=1 and no beat has occurred.
- Head override: if any valid requester i has req_robid_i == rob_head_robid, grant the lowest such i. ptr is unchanged.
- Round-robin: otherwise, grant the first valid i scanning ptr, ptr+1, ..., wrapping modulo NREQ. Then ptr <= (granted i + 1) mod NREQ; the wrap from NREQ-1 goes to 0.
- No valid requester: no grant, ptr holds, wb_valid <= 0 next cycle.
- Latency: exactly 1 cycle. Payload granted in cycle T appears on wb_* in cycle T+1 with wb_valid=1. Throughput is 1 writeback per cycle. There is no backpressure from the ROB.
- wb_* payload registers load only on a grant and hold their value otherwise. Only wb_valid is cleared.
- rob_flush=1 in cycle T:
  - req_ready=0 for all requesters in T (no beat).
  - wb_valid <= 0 at the end of T, killing any grant from T.
  - ptr <= 0.
  - A wb_valid already high in cycle T is still presented. The ROB ignores it because of its own flush.
- rst has precedence over rob_flush; both clear the same state.
- Requesters deasserting req_valid in the flush cycle is legal. The arbiter keeps no per-requester storage, so nothing is left stale.
- Width rules: robid comparison is the full 7 bits. ecause and result pass through unmodified.
- Invariant (assert): $onehot0(req_ready); req_ready & ~req_valid == 0.

Test Plan:
1. Reset, then idle: rst=1 for 2 cycles, then no requests -> all wb_* = 0, req_ready=0, ptr=0.
2. Single request: req_valid=4'b0010, robid1=7'd5, result1=32'hDEADBEEF -> req_ready=4'b0010 in T; in T+1, wb_valid=1, wb_robid=5, wb_result=DEADBEEF. In T+2, wb_valid=0.
3. Round-robin fairness: req_valid=4'b1111 held for 8 cycles, rob_head_robid matches none -> grant order 0,1,2,3,0,1,2,3, with wb_valid=1 on every cycle from T+1.
4. Head override: ptr=0; req_valid=4'b0101; robid0=9, robid2=3, rob_head_robid=3 -> req2 is granted and ptr stays 0. Next cycle only req0 is valid -> req0 is granted and ptr becomes 1.
5. Flush: req_valid=4'b1111 in cycle T with rob_flush=1 -> req_ready=0 in T, wb_valid=0 in T+1, ptr=0. In T+1, req_valid=4'b1000 -> req3 granted.
6. Error propagation with wrap: ptr=3, req_valid=4'b1001, req3 error=1, ecause=5'd4 -> req3 is granted; next cycle wb_error=1, wb_ecause=4, and ptr becomes 0.
